// File: rtl/fp_sub_pkg.sv
// Shared constants and encodings for the sequential floating-point subtractor.
package fp_sub_pkg;

    // FSM state encodings
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADDSUB = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Status byte bit positions (DesignWare adder layout)
    localparam int unsigned STAT_ZERO    = 0;
    localparam int unsigned STAT_INF     = 1;
    localparam int unsigned STAT_INVALID = 2;
    localparam int unsigned STAT_TINY    = 3;
    localparam int unsigned STAT_HUGE    = 4;
    localparam int unsigned STAT_INEXACT = 5;

    // Rounding modes; codes above RND_DOWN are folded to RND_RNE at capture
    localparam logic [2:0] RND_RNE  = 3'd0;
    localparam logic [2:0] RND_RTZ  = 3'd1;
    localparam logic [2:0] RND_UP   = 3'd2;
    localparam logic [2:0] RND_DOWN = 3'd3;

    localparam int unsigned ENC_W = 64;

    // Signed infinity, right-aligned in a 64-bit word; caller truncates to its width
    function automatic logic [ENC_W-1:0] inf_enc(input int unsigned ew, input int unsigned sw,
                                                 input logic s);
        logic [ENC_W-1:0] e_ones;
        e_ones = (ENC_W'(1) << ew) - ENC_W'(1);
        return (ENC_W'(s) << (ew + sw)) | (e_ones << sw);
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set
    function automatic logic [ENC_W-1:0] nan_enc(input int unsigned ew, input int unsigned sw);
        logic [ENC_W-1:0] e_ones;
        e_ones = (ENC_W'(1) << ew) - ENC_W'(1);
        return (e_ones << sw) | (ENC_W'(1) << (sw - 1));
    endfunction

endpackage

// File: rtl/fp_sub_round.sv
// Combinational rounding of a normalized significand with guard/round/sticky.
module fp_sub_round
    import fp_sub_pkg::*;
#(
    parameter int unsigned sig_width = 23,
    parameter int unsigned exp_width = 8
) (
    input  logic                         sign,
    input  logic [exp_width:0]           expo,
    input  logic [sig_width:0]           sig,
    input  logic                         g,
    input  logic                         r,
    input  logic                         s,
    input  logic [2:0]                   rnd,
    output logic [sig_width+exp_width:0] z,
    output logic                         huge,
    output logic                         inexact
);
    localparam logic [exp_width:0] EXP_MAX = {1'b0, {exp_width{1'b1}}};

    logic                 lost;
    logic                 up;
    logic                 to_inf;
    logic [sig_width+1:0] sum;
    logic [sig_width:0]   sig_r;
    logic [exp_width:0]   exp_r;

    // Round-up decision, carry renormalization and overflow handling
    always_comb begin
        lost = g | r | s;
        case (rnd)
            RND_RTZ:  up = 1'b0;
            RND_UP:   up = ~sign & lost;
            RND_DOWN: up = sign & lost;
            default:  up = g & (r | s | sig[0]);
        endcase
        sum = {1'b0, sig} + {{(sig_width+1){1'b0}}, up};
        if (sum[sig_width+1]) begin
            sig_r = sum[sig_width+1:1];
            exp_r = expo + 1'b1;
        end else begin
            sig_r = sum[sig_width:0];
            exp_r = expo;
        end
        to_inf  = (rnd == RND_RNE) || ((rnd == RND_UP) && !sign) || ((rnd == RND_DOWN) && sign);
        huge    = 1'b0;
        inexact = lost;
        z       = {sign, exp_r[exp_width-1:0], sig_r[sig_width-1:0]};
        if (exp_r >= EXP_MAX) begin
            huge    = 1'b1;
            inexact = 1'b1;
            z       = to_inf ? {sign, {exp_width{1'b1}}, {sig_width{1'b0}}}
                             : {sign, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
        end
    end

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 subtractor z = a - b; normalizes one bit per cycle.
module fp_sub_seq
    import fp_sub_pkg::*;
#(
    parameter int unsigned sig_width = 23,
    parameter int unsigned exp_width = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [sig_width+exp_width:0] a,
    input  logic [sig_width+exp_width:0] b,
    input  logic [2:0]                   rnd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [sig_width+exp_width:0] z,
    output logic [7:0]                   status
);
    localparam int unsigned W  = sig_width + exp_width + 1;
    localparam int unsigned MW = sig_width + 1;   // significand with hidden bit
    localparam int unsigned XW = sig_width + 4;   // significand + guard/round/sticky
    localparam int unsigned EW = exp_width + 1;   // working exponent with overflow headroom
    localparam int unsigned AW = sig_width + 3;   // alignment saturation distance
    localparam logic [exp_width-1:0] EMAX = '1;
    localparam logic [7:0] ZERO_FLAGS = 8'(1) << STAT_ZERO;

    logic [STATE_W-1:0]   state, state_nxt;
    logic [W-1:0]         a_q, b_q;
    logic [2:0]           rnd_q;
    logic                 sa_q, sb_q;
    logic [exp_width-1:0] ea_q, eb_q;
    logic [MW-1:0]        ma_q, mb_q;
    logic                 sx_q, sub_q;
    logic [exp_width-1:0] ex_q;
    logic [XW-1:0]        mx_q, my_q;
    logic [XW:0]          sum_q;
    logic [EW-1:0]        e_q;
    logic                 s_q, first_q, tiny_q;

    logic                 zero_a, zero_b, inf_a, inf_b, special;
    logic [W-1:0]         spec_z;
    logic [7:0]           spec_status;
    logic                 a_ge, xs;
    logic [exp_width-1:0] xe, ye, d;
    logic [MW-1:0]        xm, ym;
    logic [2*AW-1:0]      wide;
    logic [XW-1:0]        y_al;
    logic [XW:0]          sum_c;
    logic [W-1:0]         rz, round_z;
    logic                 rhuge, rinexact;
    logic [7:0]           round_status;

    // Operand classification; denormals count as zero, NaNs as infinity
    always_comb begin
        zero_a  = (ea_q == '0);
        zero_b  = (eb_q == '0);
        inf_a   = (ea_q == EMAX);
        inf_b   = (eb_q == EMAX);
        special = zero_a | zero_b | inf_a | inf_b;
    end

    // Result for special operands, short-circuiting the arithmetic path
    always_comb begin
        spec_z      = '0;
        spec_status = '0;
        if (inf_a && inf_b && (sa_q != sb_q)) begin
            spec_z                    = W'(nan_enc(exp_width, sig_width));
            spec_status[STAT_INVALID] = 1'b1;
        end else if (inf_a || inf_b) begin
            spec_z                = W'(inf_enc(exp_width, sig_width, inf_a ? sa_q : sb_q));
            spec_status[STAT_INF] = 1'b1;
        end else if (zero_a && zero_b) begin
            spec_z                 = {sa_q & sb_q, {(W-1){1'b0}}};
            spec_status[STAT_ZERO] = 1'b1;
        end else if (zero_a) begin
            spec_z = {sb_q, eb_q, mb_q[sig_width-1:0]};
        end else begin
            spec_z = {sa_q, ea_q, ma_q[sig_width-1:0]};
        end
    end

    // Swap so |x| >= |y|, then barrel-shift y keeping guard/round/sticky
    always_comb begin
        a_ge = ({ea_q, ma_q} >= {eb_q, mb_q});
        xs   = a_ge ? sa_q : sb_q;
        xe   = a_ge ? ea_q : eb_q;
        ye   = a_ge ? eb_q : ea_q;
        xm   = a_ge ? ma_q : mb_q;
        ym   = a_ge ? mb_q : ma_q;
        d    = xe - ye;
        wide = {ym, 2'b00, {AW{1'b0}}} >> d;
        if (d >= exp_width'(AW)) begin
            y_al = {{(XW-1){1'b0}}, 1'b1};
        end else begin
            y_al = {wide[2*AW-1:AW], |wide[AW-1:0]};
        end
    end

    // Magnitude add/subtract with a carry bit
    always_comb begin
        if (sub_q) sum_c = {1'b0, mx_q} - {1'b0, my_q};
        else       sum_c = {1'b0, mx_q} + {1'b0, my_q};
    end

    fp_sub_round #(
        .sig_width(sig_width),
        .exp_width(exp_width)
    ) u_round (
        .sign    (s_q),
        .expo    (e_q),
        .sig     (sum_q[XW-1:3]),
        .g       (sum_q[2]),
        .r       (sum_q[1]),
        .s       (sum_q[0]),
        .rnd     (rnd_q),
        .z       (rz),
        .huge    (rhuge),
        .inexact (rinexact)
    );

    // Final result selection, flushing tiny results to a signed zero
    always_comb begin
        round_z      = rz;
        round_status = '0;
        if (tiny_q) begin
            round_z                    = {s_q, {(W-1){1'b0}}};
            round_status[STAT_TINY]    = 1'b1;
            round_status[STAT_ZERO]    = 1'b1;
            round_status[STAT_INEXACT] = 1'b1;
        end else begin
            round_status[STAT_HUGE]    = rhuge;
            round_status[STAT_INEXACT] = rinexact;
            round_status[STAT_INF]     = (rz[W-2:sig_width] == EMAX);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_ALIGN;
            S_ALIGN:  state_nxt = special ? S_DONE : S_ADDSUB;
            S_ADDSUB: state_nxt = S_NORM;
            S_NORM: begin
                if (first_q && (sum_q == '0))                state_nxt = S_DONE;
                else if (first_q && sum_q[XW])               state_nxt = S_ROUND;
                else if (sum_q[XW-1] || (e_q == EW'(1)))     state_nxt = S_ROUND;
            end
            S_ROUND:  state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z         <= '0;
            status    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rnd_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            sx_q      <= 1'b0;
            sub_q     <= 1'b0;
            ex_q      <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            sum_q     <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            first_q   <= 1'b0;
            tiny_q    <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= {~b[W-1], b[W-2:0]};
                        rnd_q <= (rnd > RND_DOWN) ? RND_RNE : rnd;
                    end
                end
                S_UNPACK: begin
                    sa_q <= a_q[W-1];
                    ea_q <= a_q[W-2:sig_width];
                    ma_q <= {|a_q[W-2:sig_width], a_q[sig_width-1:0]};
                    sb_q <= b_q[W-1];
                    eb_q <= b_q[W-2:sig_width];
                    mb_q <= {|b_q[W-2:sig_width], b_q[sig_width-1:0]};
                end
                S_ALIGN: begin
                    if (special) begin
                        z      <= spec_z;
                        status <= spec_status;
                    end else begin
                        sx_q  <= xs;
                        ex_q  <= xe;
                        mx_q  <= {xm, 3'b000};
                        my_q  <= y_al;
                        sub_q <= sa_q ^ sb_q;
                    end
                end
                S_ADDSUB: begin
                    sum_q   <= sum_c;
                    e_q     <= {1'b0, ex_q};
                    s_q     <= sx_q;
                    first_q <= 1'b1;
                    tiny_q  <= 1'b0;
                end
                S_NORM: begin
                    first_q <= 1'b0;
                    if (first_q && (sum_q == '0)) begin
                        // exact cancellation: +0, or -0 when rounding toward -inf
                        z      <= {rnd_q == RND_DOWN, {(W-1){1'b0}}};
                        status <= ZERO_FLAGS;
                    end else if (first_q && sum_q[XW]) begin
                        sum_q <= {1'b0, sum_q[XW:2], sum_q[1] | sum_q[0]};
                        e_q   <= e_q + 1'b1;
                    end else if (sum_q[XW-1]) begin
                        tiny_q <= 1'b0;
                    end else if (e_q == EW'(1)) begin
                        tiny_q <= 1'b1;
                    end else begin
                        sum_q <= sum_q << 1;
                        e_q   <= e_q - 1'b1;
                    end
                end
                S_ROUND: begin
                    z      <= round_z;
                    status <= round_status;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed self-checking bench for fp_sub_seq (single precision).
module tb_fp_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [7:0]  status;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .status    (status)
    );

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Issue one operation, measure latency from the transfer edge, check result
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [2:0] rv, input logic [31:0] zw, input logic [7:0] sw,
                          input int lw, input bit release_out);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        rnd      = rv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, " latency"}, 32'(lat), 32'(lw));
        check({tag, " z"}, z, zw);
        check({tag, " status"}, 32'(status), 32'(sw));
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
            check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        rnd       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset z",         z,              32'h0000_0000);
        check("reset status",    32'(status),    32'h00);

        run_op("3-1",          32'h4040_0000, 32'h3F80_0000, 3'd0, 32'h4000_0000, 8'h00, 5,  1'b1);
        run_op("1-1ulp",       32'h3F80_0000, 32'h3F80_0001, 3'd0, 32'hB400_0000, 8'h00, 28, 1'b1);
        run_op("1-1 rne",      32'h3F80_0000, 32'h3F80_0000, 3'd0, 32'h0000_0000, 8'h01, 4,  1'b1);
        run_op("1-1 rdn",      32'h3F80_0000, 32'h3F80_0000, 3'd3, 32'h8000_0000, 8'h01, 4,  1'b1);
        run_op("ovf rne",      32'h7F7F_FFFF, 32'hFF7F_FFFF, 3'd0, 32'h7F80_0000, 8'h32, 5,  1'b1);
        run_op("ovf rtz",      32'h7F7F_FFFF, 32'hFF7F_FFFF, 3'd1, 32'h7F7F_FFFF, 8'h30, 5,  1'b1);
        run_op("inf-inf",      32'h7F80_0000, 32'h7F80_0000, 3'd0, 32'h7FC0_0000, 8'h04, 2,  1'b1);
        run_op("nan-1",        32'h7FC0_0000, 32'h3F80_0000, 3'd0, 32'h7F80_0000, 8'h02, 2,  1'b1);
        run_op("-inf-1",       32'hFF80_0000, 32'h3F80_0000, 3'd0, 32'hFF80_0000, 8'h02, 2,  1'b1);
        run_op("0-1",          32'h0000_0000, 32'h3F80_0000, 3'd0, 32'hBF80_0000, 8'h00, 2,  1'b1);
        run_op("-0-0",         32'h8000_0000, 32'h0000_0000, 3'd0, 32'h8000_0000, 8'h01, 2,  1'b1);
        run_op("1+1",          32'h3F80_0000, 32'hBF80_0000, 3'd0, 32'h4000_0000, 8'h00, 5,  1'b1);
        run_op("tie rne",      32'h3F80_0000, 32'h3300_0000, 3'd0, 32'h3F80_0000, 8'h20, 6,  1'b1);
        run_op("tie rtz",      32'h3F80_0000, 32'h3300_0000, 3'd1, 32'h3F7F_FFFF, 8'h20, 6,  1'b1);
        run_op("tie up",       32'h3F80_0000, 32'h3300_0000, 3'd2, 32'h3F80_0000, 8'h20, 6,  1'b1);
        run_op("tie down",     32'h3F80_0000, 32'h3300_0000, 3'd3, 32'h3F7F_FFFF, 8'h20, 6,  1'b1);
        run_op("tie rnd5",     32'h3F80_0000, 32'h3300_0000, 3'd5, 32'h3F80_0000, 8'h20, 6,  1'b1);
        run_op("tiny flush",   32'h0080_0000, 32'h00C0_0000, 3'd0, 32'h8000_0000, 8'h29, 5,  1'b1);

        // Consumer stall: result must hold and new operands must be ignored
        run_op("stall", 32'h4040_0000, 32'h3F80_0000, 3'd0, 32'h4000_0000, 8'h00, 5, 1'b0);
        in_valid = 1'b1;
        a        = 32'h4120_0000;
        b        = 32'h3F80_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall z",         z,              32'h4000_0000);
            check("stall status",    32'(status),    32'h00);
            check("stall in_ready",  32'(in_ready),  32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release out_valid", 32'(out_valid), 32'd0);
        check("stall release in_ready",  32'(in_ready),  32'd1);

        // Reset in the middle of a long normalization discards the operation
        a        = 32'h3F80_0000;
        b        = 32'h3F80_0001;
        rnd      = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midnorm rst in_ready",  32'(in_ready),  32'd1);
        check("midnorm rst out_valid", 32'(out_valid), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        check("midnorm rst no result", 32'(seen_valid), 32'd0);
        run_op("after rst", 32'h4040_0000, 32'h3F80_0000, 3'd0, 32'h4000_0000, 8'h00, 5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
